apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, 8, PADDR/req_addr width.
REQ-002 SHALL have parameter DATA_W, 21, PWDATA/PRDATA/req/rsp data width.
REQ-003 SHALL have parameter WAIT_W, 4, PWAIT/req_wait width.
REQ-004 SHALL have parameter TIMEOUT, 32, max ACCESS cycles before abort (used only under APB_MASTER_TIMEOUT_EN).
REQ-005 SHALL have port PCLK  in  1  sole clock, rising edge; one clock, reset synchronous active-high.
REQ-006 SHALL have port PRESET  in  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid  in  1  command request.
REQ-008 SHALL have port req_ready  out  1  master can accept a command.
REQ-009 SHALL have port req_write  in  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  in  ADDR_W  target address.
REQ-011 SHALL have port req_wdata  in  DATA_W  write data.
REQ-012 SHALL have port req_wait  in  WAIT_W  slave wait-cycle count forwarded on PWAIT.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-014 SHALL have port rsp_rdata  out  DATA_W  read data (0 for writes/errors).
REQ-015 SHALL have port rsp_err  out  1  transfer aborted by timeout.
REQ-016 SHALL have ports PSEL, PENABLE, PWRITE  out  1  APB control; PADDR out ADDR_W; PWDATA out DATA_W; PWAIT out WAIT_W.
REQ-017 SHALL have ports PREADY  in  1 and PRDATA  in  DATA_W  from slave.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-019 req_ready SHALL be 1 only in IDLE; command accepted on edge where req_valid && req_ready; fields captured into registers, state -> SETUP.
REQ-020 SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PWAIT = captured values; next state ACCESS unconditionally.
REQ-021 ACCESS: PSEL=1, PENABLE=1, address/control/data held stable; state held while PREADY=0.
REQ-022 PREADY sampled 1 in ACCESS: next cycle rsp_valid=1, rsp_rdata=PRDATA if read else 0, rsp_err=0, state IDLE, PSEL=PENABLE=0.
REQ-023 IDLE: PSEL=PENABLE=0, PADDR/PWDATA/PWAIT/PWRITE=0; PREADY ignored outside ACCESS.
REQ-024 Minimum transfer latency: accept edge -> SETUP 1 cycle -> ACCESS ≥1 cycle -> rsp_valid on 3rd edge after accept; back-to-back commands produce one IDLE cycle between transfers.
REQ-025 rsp_valid SHALL be high exactly one cycle per transfer; no back-pressure; rsp_rdata/rsp_err held until next completion.
REQ-026 req_valid changes while not in IDLE SHALL have no effect on the ongoing transfer.

Reset
REQ-027 PRESET sampled high SHALL force IDLE and all outputs to 0 (req_ready=1 in following cycle), counter cleared.
REQ-028 PRESET mid-SETUP/ACCESS SHALL abort without rsp_valid; PSEL/PENABLE low after that edge.

Configuration
REQ-029 With APB_MASTER_TIMEOUT_EN defined: counter increments each ACCESS cycle with PREADY=0; reaching TIMEOUT SHALL abort: next cycle IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-030 PREADY=1 on the same cycle the counter reaches TIMEOUT SHALL complete normally (rsp_err=0).
REQ-031 Without APB_MASTER_TIMEOUT_EN: ACCESS waits indefinitely, rsp_err tied 0, no counter logic.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and default width constants (ADDR_W=8, DATA_W=21, WAIT_W=4).
REQ-033 Timeout counter SHALL be sub-module apb_timeout_ctr (clear, enable, expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-034 Write addr 0x12 data 0x1ABCD, PREADY=1 immediately -> SETUP then ACCESS 1 cycle, PWDATA=0x1ABCD, rsp_valid 3rd edge, rsp_rdata=0.
REQ-035 Read addr 0x40, PREADY held 0 for 3 ACCESS cycles, PRDATA=0x0F0F0 -> PSEL/PENABLE/PADDR stable 4 ACCESS cycles, rsp_rdata=0x0F0F0.
REQ-036 req_valid held high for 2 commands -> 2 transfers, one IDLE cycle between, two single-cycle rsp_valid pulses.
REQ-037 PRESET asserted during ACCESS -> next edge all outputs 0, no rsp_valid, req_ready=1.
REQ-038 TIMEOUT_EN, TIMEOUT=32, PREADY never 1 -> abort after 32 ACCESS cycles, rsp_err=1, rsp_rdata=0; PREADY=1 on 32nd cycle -> rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master.
package apb_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 21;
    localparam int unsigned DEF_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts stalled ACCESS cycles; expired fires on the TIMEOUT-th stalled cycle.
module apb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count stalled cycles; cleared whenever the master is not in ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count already holds TIMEOUT-1 earlier stalls, so this stall is the last one allowed.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, IDLE/SETUP/ACCESS transfer, one-cycle response.
// Optional ACCESS timeout abort is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned WAIT_W  = DEF_WAIT_W,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [WAIT_W-1:0] req_wait,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [WAIT_W-1:0] PWAIT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_e        state_q;
    logic              req_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [WAIT_W-1:0] pwait_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_err_q;
    logic tmo_expired;

    apb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (state_q != ACCESS),
        .enable  ((state_q == ACCESS) && !PREADY),
        .expired (tmo_expired)
    );
`endif

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwait_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= SETUP;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= req_write;
                        paddr_q     <= req_addr;
                        pwdata_q    <= req_wdata;
                        pwait_q     <= req_wait;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        pwait_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_expired) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        pwait_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWAIT     = pwait_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized checks of apb_master against a transfer-level model.
module tb_apb_master;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 21;
    localparam int unsigned WAIT_W  = 4;
    localparam int          TIMEOUT = 32;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [WAIT_W-1:0] req_wait;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [WAIT_W-1:0] PWAIT;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] prev_rdata;

    apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wait  (req_wait),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWAIT     (PWAIT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_psel"}, 32'(PSEL), 32'd0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        chk({tag, "_paddr"}, 32'(PADDR), 32'd0);
        chk({tag, "_pwdata"}, 32'(PWDATA), 32'd0);
        chk({tag, "_pwait"}, 32'(PWAIT), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One complete transfer. Starts with the master idle; ends in the response cycle.
    // The model: stalled for n_wait ACCESS cycles, then PREADY; timeout caps ACCESS length.
    task automatic xfer(input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [WAIT_W-1:0] wt,
                        input int n_wait, input logic [DATA_W-1:0] prdata, input bit hold);
        bit                err;
        int                n_acc;
        logic [DATA_W-1:0] exp_rd;
        err    = TMO && (n_wait >= TIMEOUT);
        n_acc  = err ? TIMEOUT : n_wait + 1;
        exp_rd = (wr || err) ? '0 : prdata;

        chk("pre_ready", 32'(req_ready), 32'd1);
        chk("pre_psel", 32'(PSEL), 32'd0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wait  = wt;
        PREADY    = 1'b0;
        step();

        // SETUP: request lines now scrambled and must be ignored.
        req_valid = hold ? 1'b1 : 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = DATA_W'($urandom);
        req_wait  = WAIT_W'($urandom);
        PREADY    = 1'($urandom);
        PRDATA    = DATA_W'($urandom);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", 32'(PADDR), 32'(addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("setup_pwdata", 32'(PWDATA), 32'(wdata));
        chk("setup_pwait", 32'(PWAIT), 32'(wt));
        chk("setup_ready", 32'(req_ready), 32'd0);
        chk("setup_rspv", 32'(rsp_valid), 32'd0);
        chk("setup_rdata_held", 32'(rsp_rdata), 32'(prev_rdata));
        step();

        for (int k = 1; k <= n_acc; k++) begin
            chk("acc_psel", 32'(PSEL), 32'd1);
            chk("acc_penable", 32'(PENABLE), 32'd1);
            chk("acc_paddr", 32'(PADDR), 32'(addr));
            chk("acc_pwdata", 32'(PWDATA), 32'(wdata));
            chk("acc_pwrite", 32'(PWRITE), 32'(wr));
            chk("acc_rspv", 32'(rsp_valid), 32'd0);
            PREADY = (k > n_wait);
            PRDATA = (k > n_wait) ? prdata : DATA_W'($urandom);
            step();
        end

        // Response cycle (master back in IDLE); PREADY must be ignored here.
        PREADY = 1'($urandom);
        PRDATA = DATA_W'($urandom);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk_all_idle("rsp");
        prev_rdata = exp_rd;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_rspv", 32'(rsp_valid), 32'd0);
            chk("idle_rdata_held", 32'(rsp_rdata), 32'(prev_rdata));
            chk("idle_ready", 32'(req_ready), 32'd1);
        end
        PREADY = 1'b0;
    endtask

    initial begin
        PRESET     = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wait   = '0;
        PREADY     = 1'b0;
        PRDATA     = '0;
        prev_rdata = '0;
        step();
        step();
        chk_all_idle("reset");
        chk("reset_rspv", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        PRESET = 1'b0;
        step();

        // Zero-wait write, then a read stalled three cycles.
        xfer(1'b1, 8'h12, 21'h1ABCD, 4'h0, 0, 21'h0, 1'b0);
        idle_cycles(2);
        xfer(1'b0, 8'h40, 21'h0, 4'h3, 3, 21'h0F0F0, 1'b0);
        idle_cycles(1);

        // Back-to-back commands with req_valid held high.
        xfer(1'b0, 8'hA5, 21'h0, 4'h1, 1, 21'h15555, 1'b1);
        xfer(1'b1, 8'h5A, 21'h0AAAA, 4'hF, 0, 21'h1FFFF, 1'b0);
        idle_cycles(1);

        // Long stalls: timeout boundary (aborts only with the timeout feature built in).
        xfer(1'b0, 8'h77, 21'h0, 4'h2, 40, 21'h12345, 1'b0);
        idle_cycles(1);
        xfer(1'b0, 8'h78, 21'h0, 4'h2, TIMEOUT - 1, 21'h0BEEF, 1'b0);
        idle_cycles(1);
        xfer(1'b0, 8'h79, 21'h0, 4'h2, TIMEOUT, 21'h1CAFE, 1'b0);
        idle_cycles(1);

        // Reset in the middle of ACCESS: abort with no response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h33;
        req_wdata = 21'h00777;
        req_wait  = 4'h5;
        step();
        req_valid = 1'b0;
        step();
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        prev_rdata = '0;
        chk_all_idle("midreset");
        chk("midreset_rspv", 32'(rsp_valid), 32'd0);
        chk("midreset_rdata", 32'(rsp_rdata), 32'd0);
        chk("midreset_err", 32'(rsp_err), 32'd0);
        idle_cycles(2);

        // Randomized transfers.
        for (int t = 0; t < 25; t++) begin
            int  nw;
            bit  hold;
            nw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(28, 36))
                                               : int'($urandom_range(0, 4));
            hold = 1'($urandom);
            xfer(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), WAIT_W'($urandom),
                 nw, DATA_W'($urandom), hold);
            if (!hold) idle_cycles(int'($urandom_range(1, 2)));
        end
        req_valid = 1'b0;
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
